rgb_switch_debouncer: RTL and testbench



---
 rtl/rgb_switch_debouncer.sv | 69 ++++++
 tb/tb_rgb_switch_debouncer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rgb_switch_debouncer.sv
// Two-flop synchroniser and per-bit stability counter for the RGB colour switches.
// sw_out follows a steady input DEBOUNCE_CYCLES+1 edges after first sample; registered event strobes, no handshake.
module rgb_switch_debouncer #(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] w_acc;

  // A bit is accepted on the edge where it has differed for the full window.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_acc[i] = (r_s2[i] != r_out[i]) && (r_cnt[i] == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_out     <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1      <= sw_in;
      r_s2      <= r_s1;
      r_out     <= r_out ^ w_acc;
      r_rise    <= w_acc & r_s2;
      r_fall    <= w_acc & ~r_s2;
      r_changed <= |w_acc;
      for (int i = 0; i < WIDTH; i++) begin
        if ((r_s2[i] == r_out[i]) || w_acc[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sw_out  = r_out;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign changed = r_changed;

endmodule

// File: tb/tb_rgb_switch_debouncer.sv
// Directed per-cycle vectors for the switch debouncer with DEBOUNCE_CYCLES=4.
module tb_rgb_switch_debouncer;

  logic       clk;
  logic       rst;
  logic [5:0] sw_in;
  logic [5:0] sw_out;
  logic [5:0] rise;
  logic [5:0] fall;
  logic       changed;

  int total;
  int bad;

  rgb_switch_debouncer #(
    .WIDTH          (6),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [5:0] sw_in;
    logic [5:0] out;
    logic [5:0] rise;
    logic [5:0] fall;
    logic       chg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic [5:0] i,
                     input logic [5:0] o, input logic [5:0] ri,
                     input logic [5:0] fa, input logic c);
    vec_t v;
    v.rst = r; v.sw_in = i; v.out = o; v.rise = ri; v.fall = fa; v.chg = c;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic cmp6(input string nm, input int idx, input logic [5:0] got,
                      input logic [5:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step %0d got=%b want=%b", nm, idx, got, want);
    end
  endtask

  // Drive inputs away from the edge, clock once, then sample just after the edge.
  task automatic step(input string nm, input int idx, input logic r,
                      input logic [5:0] i, input logic [5:0] o,
                      input logic [5:0] ri, input logic [5:0] fa, input logic c);
    rst   = r;
    sw_in = i;
    @(posedge clk);
    #1;
    cmp6({nm, ".sw_out"}, idx, sw_out, o);
    cmp6({nm, ".rise"}, idx, rise, ri);
    cmp6({nm, ".fall"}, idx, fall, fa);
    cmp6({nm, ".changed"}, idx, {5'b0, changed}, {5'b0, c});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    sw_in = 6'b111111;

    // reset held with all switches high, then full latency to accept
    add(3, 1'b1, 6'h3F, 6'h00, 6'h00, 6'h00, 1'b0);
    add(5, 1'b0, 6'h3F, 6'h00, 6'h00, 6'h00, 1'b0);
    add(1, 1'b0, 6'h3F, 6'h3F, 6'h3F, 6'h00, 1'b1);
    add(1, 1'b0, 6'h3F, 6'h3F, 6'h00, 6'h00, 1'b0);
    // all back to zero
    add(5, 1'b0, 6'h00, 6'h3F, 6'h00, 6'h00, 1'b0);
    add(1, 1'b0, 6'h00, 6'h00, 6'h00, 6'h3F, 1'b1);
    add(1, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0);
    // single rise on bit 0
    add(5, 1'b0, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0);
    add(1, 1'b0, 6'h01, 6'h01, 6'h01, 6'h00, 1'b1);
    add(2, 1'b0, 6'h01, 6'h01, 6'h00, 6'h00, 1'b0);
    // single fall on bit 0
    add(5, 1'b0, 6'h00, 6'h01, 6'h00, 6'h00, 1'b0);
    add(1, 1'b0, 6'h00, 6'h00, 6'h00, 6'h01, 1'b1);
    add(1, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0);
    // 3-cycle glitch on bit 3 is rejected
    add(3, 1'b0, 6'h08, 6'h00, 6'h00, 6'h00, 1'b0);
    add(6, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0);
    // 4-cycle pulse on bit 3 is just long enough, then falls back
    add(4, 1'b0, 6'h08, 6'h00, 6'h00, 6'h00, 1'b0);
    add(1, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0);
    add(1, 1'b0, 6'h00, 6'h08, 6'h08, 6'h00, 1'b1);
    add(3, 1'b0, 6'h00, 6'h08, 6'h00, 6'h00, 1'b0);
    add(1, 1'b0, 6'h00, 6'h00, 6'h00, 6'h08, 1'b1);
    add(1, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0);
    // simultaneous rise then fall on three bits
    add(5, 1'b0, 6'h2A, 6'h00, 6'h00, 6'h00, 1'b0);
    add(1, 1'b0, 6'h2A, 6'h2A, 6'h2A, 6'h00, 1'b1);
    add(1, 1'b0, 6'h2A, 6'h2A, 6'h00, 6'h00, 1'b0);
    add(5, 1'b0, 6'h00, 6'h2A, 6'h00, 6'h00, 1'b0);
    add(1, 1'b0, 6'h00, 6'h00, 6'h00, 6'h2A, 1'b1);
    add(1, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0);

    foreach (vecs[k]) begin
      step("vec", k, vecs[k].rst, vecs[k].sw_in, vecs[k].out,
           vecs[k].rise, vecs[k].fall, vecs[k].chg);
    end

    // staggered: bit 0 at E0, bit 5 at E0+2 -> two separate accepts
    step("stag", 0, 1'b0, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0);
    step("stag", 1, 1'b0, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0);
    for (int k = 2; k < 5; k++)
      step("stag", k, 1'b0, 6'h21, 6'h00, 6'h00, 6'h00, 1'b0);
    step("stag", 5, 1'b0, 6'h21, 6'h01, 6'h01, 6'h00, 1'b1);
    step("stag", 6, 1'b0, 6'h21, 6'h01, 6'h00, 6'h00, 1'b0);
    step("stag", 7, 1'b0, 6'h21, 6'h21, 6'h20, 6'h00, 1'b1);
    step("stag", 8, 1'b0, 6'h21, 6'h21, 6'h00, 6'h00, 1'b0);
    for (int k = 9; k < 14; k++)
      step("stag", k, 1'b0, 6'h00, 6'h21, 6'h00, 6'h00, 1'b0);
    step("stag", 14, 1'b0, 6'h00, 6'h00, 6'h00, 6'h21, 1'b1);
    step("stag", 15, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 1'b0);

    // same stimulus with reset at E0+3: partial counts discarded
    step("rstmid", 0, 1'b0, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0);
    step("rstmid", 1, 1'b0, 6'h01, 6'h00, 6'h00, 6'h00, 1'b0);
    step("rstmid", 2, 1'b0, 6'h21, 6'h00, 6'h00, 6'h00, 1'b0);
    step("rstmid", 3, 1'b1, 6'h21, 6'h00, 6'h00, 6'h00, 1'b0);
    for (int k = 4; k < 9; k++)
      step("rstmid", k, 1'b0, 6'h21, 6'h00, 6'h00, 6'h00, 1'b0);
    step("rstmid", 9, 1'b0, 6'h21, 6'h21, 6'h21, 6'h00, 1'b1);
    step("rstmid", 10, 1'b0, 6'h21, 6'h21, 6'h00, 6'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
